// File: rtl/sensor_pwr_seq.sv
// Image-sensor power sequencer: brings up 3V3, 1V8, 1V2, INCK and XCLR in order
// with fixed dwell times, tears them down in reverse, and drops everything on fault.
module sensor_pwr_seq #(
    parameter int CNT_W = 20,
    parameter int T_A   = 50000,
    parameter int T_B   = 50000,
    parameter int T_C   = 50000,
    parameter int T_D   = 25000,
    parameter int T_E   = 50000,
    parameter int T_DN  = 25000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pwr_req,
    input  logic       fault,
    input  logic       fault_clr,
    output logic       reg_3v3_en_o,
    output logic       reg_1v8_en_o,
    output logic       reg_1v2_en_o,
    output logic       inck_en_o,
    output logic       xclr_o,
    output logic       ready_o,
    output logic       busy_o,
    output logic       fault_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        OFF     = 4'd0,
        UP_3V3  = 4'd1,
        UP_1V8  = 4'd2,
        UP_1V2  = 4'd3,
        UP_INCK = 4'd4,
        UP_XCLR = 4'd5,
        ON      = 4'd6,
        DN_XCLR = 4'd7,
        DN_INCK = 4'd8,
        DN_1V2  = 4'd9,
        DN_1V8  = 4'd10,
        DN_3V3  = 4'd11,
        FAULT   = 4'd15
    } state_t;

    localparam logic [CNT_W-1:0] DW_A  = CNT_W'(T_A);
    localparam logic [CNT_W-1:0] DW_B  = CNT_W'(T_B);
    localparam logic [CNT_W-1:0] DW_C  = CNT_W'(T_C);
    localparam logic [CNT_W-1:0] DW_D  = CNT_W'(T_D);
    localparam logic [CNT_W-1:0] DW_E  = CNT_W'(T_E);
    localparam logic [CNT_W-1:0] DW_DN = CNT_W'(T_DN);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dwell_done;

    // rails_d bit order: {xclr, inck, 1v2, 1v8, 3v3}
    logic [4:0]       rails_d;
    logic             ready_d;
    logic             busy_d;
    logic             fault_d;

    function automatic logic [CNT_W-1:0] dwell_of(input state_t s);
        case (s)
            UP_3V3:  dwell_of = DW_A;
            UP_1V8:  dwell_of = DW_B;
            UP_1V2:  dwell_of = DW_C;
            UP_INCK: dwell_of = DW_D;
            UP_XCLR: dwell_of = DW_E;
            DN_XCLR, DN_INCK, DN_1V2, DN_1V8, DN_3V3: dwell_of = DW_DN;
            default: dwell_of = '0;
        endcase
    endfunction

    assign dwell_done = (cnt_q == ONE);

    // An abort jumps to the DN state that clears the output just enabled.
    always_comb begin
        state_d = state_q;
        if (fault) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                OFF:     if (pwr_req) state_d = UP_3V3;
                UP_3V3:  if (!pwr_req) state_d = DN_3V3;
                         else if (dwell_done) state_d = UP_1V8;
                UP_1V8:  if (!pwr_req) state_d = DN_1V8;
                         else if (dwell_done) state_d = UP_1V2;
                UP_1V2:  if (!pwr_req) state_d = DN_1V2;
                         else if (dwell_done) state_d = UP_INCK;
                UP_INCK: if (!pwr_req) state_d = DN_INCK;
                         else if (dwell_done) state_d = UP_XCLR;
                UP_XCLR: if (!pwr_req) state_d = DN_XCLR;
                         else if (dwell_done) state_d = ON;
                ON:      if (!pwr_req) state_d = DN_XCLR;
                DN_XCLR: if (dwell_done) state_d = DN_INCK;
                DN_INCK: if (dwell_done) state_d = DN_1V2;
                DN_1V2:  if (dwell_done) state_d = DN_1V8;
                DN_1V8:  if (dwell_done) state_d = DN_3V3;
                DN_3V3:  if (dwell_done) state_d = OFF;
                FAULT:   if (fault_clr) state_d = OFF;
                default: state_d = FAULT;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = dwell_of(state_d);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Outputs are a pure decode of the next state, registered on the same edge.
    always_comb begin
        rails_d = 5'b00000;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        fault_d = 1'b0;
        case (state_d)
            UP_3V3:  begin rails_d = 5'b00001; busy_d = 1'b1; end
            UP_1V8:  begin rails_d = 5'b00011; busy_d = 1'b1; end
            UP_1V2:  begin rails_d = 5'b00111; busy_d = 1'b1; end
            UP_INCK: begin rails_d = 5'b01111; busy_d = 1'b1; end
            UP_XCLR: begin rails_d = 5'b11111; busy_d = 1'b1; end
            ON:      begin rails_d = 5'b11111; ready_d = 1'b1; end
            DN_XCLR: begin rails_d = 5'b01111; busy_d = 1'b1; end
            DN_INCK: begin rails_d = 5'b00111; busy_d = 1'b1; end
            DN_1V2:  begin rails_d = 5'b00011; busy_d = 1'b1; end
            DN_1V8:  begin rails_d = 5'b00001; busy_d = 1'b1; end
            DN_3V3:  begin rails_d = 5'b00000; busy_d = 1'b1; end
            FAULT:   fault_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= OFF;
            cnt_q        <= '0;
            reg_3v3_en_o <= 1'b0;
            reg_1v8_en_o <= 1'b0;
            reg_1v2_en_o <= 1'b0;
            inck_en_o    <= 1'b0;
            xclr_o       <= 1'b0;
            ready_o      <= 1'b0;
            busy_o       <= 1'b0;
            fault_o      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reg_3v3_en_o <= rails_d[0];
            reg_1v8_en_o <= rails_d[1];
            reg_1v2_en_o <= rails_d[2];
            inck_en_o    <= rails_d[3];
            xclr_o       <= rails_d[4];
            ready_o      <= ready_d;
            busy_o       <= busy_d;
            fault_o      <= fault_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_sensor_pwr_seq.sv
// Bench for sensor_pwr_seq: directed scenarios plus random pwr_req/fault traffic,
// each cycle compared against a level/direction model of the power sequence.
module tb_sensor_pwr_seq;
    localparam int TA = 3, TB = 4, TC = 5, TD = 6, TE = 7, TDN = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pwr_req;
    logic       fault;
    logic       fault_clr;
    logic       reg_3v3_en_o, reg_1v8_en_o, reg_1v2_en_o, inck_en_o, xclr_o;
    logic       ready_o, busy_o, fault_o;
    logic [3:0] state_o;
    logic [11:0] dut_vec;

    int n_checks = 0;
    int n_errs   = 0;

    sensor_pwr_seq #(
        .CNT_W(20), .T_A(TA), .T_B(TB), .T_C(TC), .T_D(TD), .T_E(TE), .T_DN(TDN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pwr_req(pwr_req), .fault(fault),
        .fault_clr(fault_clr), .reg_3v3_en_o(reg_3v3_en_o),
        .reg_1v8_en_o(reg_1v8_en_o), .reg_1v2_en_o(reg_1v2_en_o),
        .inck_en_o(inck_en_o), .xclr_o(xclr_o), .ready_o(ready_o),
        .busy_o(busy_o), .fault_o(fault_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign dut_vec = {state_o, fault_o, busy_o, ready_o, xclr_o, inck_en_o,
                      reg_1v2_en_o, reg_1v8_en_o, reg_3v3_en_o};

    // Model: number of outputs switched on (in power order), direction, and time left.
    typedef enum {M_OFF, M_UP, M_ON, M_DN, M_FAULT} mode_t;
    mode_t m_mode;
    int    m_level;
    int    m_rem;

    function automatic int up_dwell(input int lvl);
        case (lvl)
            1: up_dwell = TA;
            2: up_dwell = TB;
            3: up_dwell = TC;
            4: up_dwell = TD;
            default: up_dwell = TE;
        endcase
    endfunction

    task model_reset();
        m_mode = M_OFF; m_level = 0; m_rem = 0;
    endtask

    task model_step(input logic p, input logic f, input logic c);
        if (f) begin
            m_mode = M_FAULT; m_level = 0;
        end else begin
            case (m_mode)
                M_OFF: if (p) begin m_mode = M_UP; m_level = 1; m_rem = TA; end
                M_UP: begin
                    if (!p) begin
                        m_mode = M_DN; m_level = m_level - 1; m_rem = TDN;
                    end else if (m_rem == 1) begin
                        if (m_level == 5) m_mode = M_ON;
                        else begin m_level = m_level + 1; m_rem = up_dwell(m_level); end
                    end else m_rem = m_rem - 1;
                end
                M_ON: if (!p) begin m_mode = M_DN; m_level = 4; m_rem = TDN; end
                M_DN: begin
                    if (m_rem == 1) begin
                        if (m_level == 0) m_mode = M_OFF;
                        else begin m_level = m_level - 1; m_rem = TDN; end
                    end else m_rem = m_rem - 1;
                end
                default: if (c) m_mode = M_OFF;
            endcase
        end
    endtask

    function automatic logic [11:0] exp_vec();
        logic [4:0] rails;
        logic [3:0] code;
        for (int k = 0; k < 5; k++) rails[k] = (m_level > k);
        case (m_mode)
            M_OFF:   code = 4'd0;
            M_UP:    code = 4'(m_level);
            M_ON:    code = 4'd6;
            M_DN:    code = 4'(11 - m_level);
            default: code = 4'd15;
        endcase
        exp_vec = {code, m_mode == M_FAULT, (m_mode == M_UP) || (m_mode == M_DN),
                   m_mode == M_ON, rails};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; inputs are sampled at the next edge.
    task automatic step(input logic p, input logic f, input logic c);
        pwr_req = p; fault = f; fault_clr = c;
        @(posedge clk);
        model_step(p, f, c);
        #1;
        check("cycle_vs_model", dut_vec, exp_vec());
    endtask

    task automatic run_powerup();
        int rise[6];
        int exp_rise[6];
        logic [5:0] outs;
        exp_rise = '{1, 4, 8, 13, 19, 26};
        for (int k = 0; k < 6; k++) rise[k] = -1;
        for (int i = 0; i < 27; i++) begin
            step(1'b1, 1'b0, 1'b0);
            outs = {ready_o, xclr_o, inck_en_o, reg_1v2_en_o, reg_1v8_en_o, reg_3v3_en_o};
            for (int k = 0; k < 6; k++) if (rise[k] < 0 && outs[k]) rise[k] = i + 1;
            if (i + 1 == 25) check("up_busy_25", busy_o, 1);
        end
        for (int k = 0; k < 6; k++) check($sformatf("up_rise_%0d", k), rise[k], exp_rise[k]);
        check("up_state_on", state_o, 6);
    endtask

    task automatic run_powerdown();
        int fall[6];
        int exp_fall[6];
        logic [5:0] outs;
        exp_fall = '{9, 7, 5, 3, 1, 1};
        for (int k = 0; k < 6; k++) fall[k] = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b0);
            outs = {ready_o, xclr_o, inck_en_o, reg_1v2_en_o, reg_1v8_en_o, reg_3v3_en_o};
            for (int k = 0; k < 6; k++) if (fall[k] < 0 && !outs[k]) fall[k] = i + 1;
            if (i + 1 == 10) check("dn_busy_10", busy_o, 1);
            if (i + 1 == 11) check("dn_off_11", {state_o, busy_o}, 0);
        end
        for (int k = 0; k < 6; k++) check($sformatf("dn_fall_%0d", k), fall[k], exp_fall[k]);
    endtask

    initial begin
        int  hold;
        int  f1v8, f3v3;
        logic seen_late;
        logic found;

        reset_n = 1'b0; pwr_req = 1'b0; fault = 1'b0; fault_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dut_vec, 0);
        reset_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // Full power-up then power-down from ON
        run_powerup();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        run_powerdown();

        // Abort two cycles after 1V2 rises
        repeat (10) step(1'b1, 1'b0, 1'b0);
        check("abort_pre_1v2", reg_1v2_en_o, 1);
        step(1'b0, 1'b0, 1'b0);
        check("abort_state", state_o, 9);
        check("abort_1v2_low", reg_1v2_en_o, 0);
        f1v8 = -1; f3v3 = -1; seen_late = 1'b0;
        for (int i = 2; i < 14; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (f1v8 < 0 && !reg_1v8_en_o) f1v8 = i;
            if (f3v3 < 0 && !reg_3v3_en_o) f3v3 = i;
            if (inck_en_o || xclr_o) seen_late = 1'b1;
        end
        check("abort_1v8_fall", f1v8, 3);
        check("abort_3v3_fall", f3v3, 5);
        check("abort_no_inck_xclr", seen_late, 0);
        check("abort_off", state_o, 0);

        // Re-request while in DN_INCK
        run_powerup();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (state_o == 4'd8) found = 1'b1;
        end
        check("rereq_reach_dn_inck", found, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (state_o == 4'd0) found = 1'b1;
        end
        check("rereq_reach_off", found, 1);
        step(1'b1, 1'b0, 1'b0);
        check("rereq_restart", state_o, 1);
        repeat (30) step(1'b1, 1'b0, 1'b0);
        check("rereq_on", state_o, 6);

        // Fault in ON
        step(1'b1, 1'b1, 1'b0);
        check("fault_entry", dut_vec, 12'hF80);
        step(1'b1, 1'b1, 1'b1);
        check("fault_clr_blocked", state_o, 15);
        step(1'b0, 1'b0, 1'b1);
        check("fault_clr_off", dut_vec, 0);
        repeat (2) step(1'b0, 1'b0, 1'b0);

        // Asynchronous reset during UP_INCK, then a clean restart
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (state_o == 4'd4) found = 1'b1;
        end
        check("reset_reach_up_inck", found, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_async_clear", dut_vec, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_powerup();

        // Random traffic
        hold = 0;
        for (int i = 0; i < 2500; i++) begin
            if (hold == 0) begin
                pwr_req = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 45);
            end
            hold--;
            step(pwr_req, ($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
